// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences the shared datapath through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives every enable, select and ALU op.
module multi_cycle_ctrl #(
  parameter int P_STATE_W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [5:0]           i_op,
  input  logic [5:0]           i_funct,
  input  logic                 i_zf,
  output logic [2:0]           o_aluc,
  output logic                 o_alusrca,
  output logic [1:0]           o_alusrcb,
  output logic [1:0]           o_pcsrc,
  output logic                 o_pcen,
  output logic                 o_iord,
  output logic                 o_memwrite,
  output logic                 o_irwrite,
  output logic                 o_regdst,
  output logic                 o_memtoreg,
  output logic                 o_regwrite,
  output logic                 o_done,
  output logic                 o_illegal,
  output logic [P_STATE_W-1:0] o_state
);

  typedef enum logic [P_STATE_W-1:0] {
    FETCH  = 'd0,  DECODE = 'd1,  MEMADR = 'd2,  MEMRD  = 'd3,
    MEMWB  = 'd4,  MEMWR  = 'd5,  RTEX   = 'd6,  RTWB   = 'd7,
    BEQEX  = 'd8,  JEX    = 'd9,  ADDIEX = 'd10, ADDIWB = 'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_e state_q, state_d;
  logic   funct_ok;
  logic [2:0] funct_aluc;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    funct_ok   = 1'b1;
    funct_aluc = 3'b010;
    case (i_funct)
      6'b100000: funct_aluc = 3'b010;
      6'b100010: funct_aluc = 3'b110;
      6'b100100: funct_aluc = 3'b000;
      6'b100101: funct_aluc = 3'b001;
      6'b101010: funct_aluc = 3'b111;
      default:   funct_ok   = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = FETCH;
    o_aluc     = 3'b000;
    o_alusrca  = 1'b0;
    o_alusrcb  = 2'b00;
    o_pcsrc    = 2'b00;
    o_pcen     = 1'b0;
    o_iord     = 1'b0;
    o_memwrite = 1'b0;
    o_irwrite  = 1'b0;
    o_regdst   = 1'b0;
    o_memtoreg = 1'b0;
    o_regwrite = 1'b0;
    o_done     = 1'b0;
    o_illegal  = 1'b0;
    o_state    = state_q;
    case (state_q)
      FETCH: begin
        o_irwrite = 1'b1;
        o_alusrcb = 2'b01;
        o_aluc    = 3'b010;
        o_pcen    = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        o_alusrcb = 2'b11;
        o_aluc    = 3'b010;
        case (i_op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R: begin
            if (funct_ok) state_d = RTEX;
            else          o_illegal = 1'b1;
          end
          OP_BEQ:  state_d = BEQEX;
          OP_J:    state_d = JEX;
          OP_ADDI: state_d = ADDIEX;
          default: o_illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        o_aluc    = 3'b010;
        state_d   = (i_op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        o_iord  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        o_memtoreg = 1'b1;
        o_regwrite = 1'b1;
        o_done     = 1'b1;
      end
      MEMWR: begin
        o_iord     = 1'b1;
        o_memwrite = 1'b1;
        o_done     = 1'b1;
      end
      RTEX: begin
        o_alusrca = 1'b1;
        o_aluc    = funct_aluc;
        state_d   = RTWB;
      end
      RTWB: begin
        o_regdst   = 1'b1;
        o_regwrite = 1'b1;
        o_done     = 1'b1;
      end
      BEQEX: begin
        o_alusrca = 1'b1;
        o_aluc    = 3'b110;
        o_pcsrc   = 2'b01;
        o_pcen    = i_zf;
        o_done    = 1'b1;
      end
      JEX: begin
        o_pcsrc = 2'b10;
        o_pcen  = 1'b1;
        o_done  = 1'b1;
      end
      ADDIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        o_aluc    = 3'b010;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        o_regwrite = 1'b1;
        o_done     = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // Reset blanks everything so an abandoned instruction cannot write.
    if (i_rst) begin
      o_aluc     = 3'b000;
      o_alusrca  = 1'b0;
      o_alusrcb  = 2'b00;
      o_pcsrc    = 2'b00;
      o_pcen     = 1'b0;
      o_iord     = 1'b0;
      o_memwrite = 1'b0;
      o_irwrite  = 1'b0;
      o_regdst   = 1'b0;
      o_memtoreg = 1'b0;
      o_regwrite = 1'b0;
      o_done     = 1'b0;
      o_illegal  = 1'b0;
      o_state    = '0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: per-cycle expected output vectors from an
// instruction-level model go into a queue; a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;

  localparam int W = 21;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'b100011;
  logic [5:0] funct = 6'b0;
  logic       zf = 1'b0;
  logic [2:0] aluc;
  logic       alusrca, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, done, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  multi_cycle_ctrl #(.P_STATE_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_funct(funct), .i_zf(zf),
    .o_aluc(aluc), .o_alusrca(alusrca), .o_alusrcb(alusrcb), .o_pcsrc(pcsrc),
    .o_pcen(pcen), .o_iord(iord), .o_memwrite(memwrite), .o_irwrite(irwrite),
    .o_regdst(regdst), .o_memtoreg(memtoreg), .o_regwrite(regwrite),
    .o_done(done), .o_illegal(illegal), .o_state(state)
  );

  always #5 clk = ~clk;

  // {state, aluc, alusrca, alusrcb, pcsrc, pcen, iord, memwrite, irwrite,
  //  regdst, memtoreg, regwrite, done, illegal}
  function automatic logic [W-1:0] vec(input int st, input int ac, input int sa, input int sb,
                                        input int ps, input int pe, input int io, input int mw,
                                        input int iw, input int rd, input int mr, input int rw,
                                        input int dn, input int il);
    logic [W-1:0] v;
    v = {st[3:0], ac[2:0], sa[0], sb[1:0], ps[1:0], pe[0], io[0], mw[0],
         iw[0], rd[0], mr[0], rw[0], dn[0], il[0]};
    return v;
  endfunction

  // ALU op an R-type funct should request; -1 means unsupported.
  function automatic int r_aluc(input logic [5:0] f);
    case (f)
      6'd32: return 2;
      6'd34: return 6;
      6'd36: return 0;
      6'd37: return 1;
      6'd42: return 7;
      default: return -1;
    endcase
  endfunction

  task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    rst = r; op = o; funct = f; zf = z;
    exp_q.push_back(e);
  endtask

  // One full instruction: the cycle list is derived from what each instruction
  // must do, and the FETCH cycle sees junk on op/funct.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    logic [5:0] jo, jf;
    jo = 6'($urandom_range(0, 63));
    jf = 6'($urandom_range(0, 63));
    step(0, jo, jf, z, vec(0, 2, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    case (o)
      6'b100011: begin
        step(0, o, f, z, vec(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, o, f, z, vec(2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, o, f, z, vec(3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(0, o, f, z, vec(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      end
      6'b101011: begin
        step(0, o, f, z, vec(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, o, f, z, vec(2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, o, f, z, vec(5, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
      end
      6'b000000: begin
        if (r_aluc(f) < 0) begin
          step(0, o, f, z, vec(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end else begin
          step(0, o, f, z, vec(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          step(0, o, f, z, vec(6, r_aluc(f), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          step(0, o, f, z, vec(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        end
      end
      6'b000100: begin
        step(0, o, f, z, vec(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, o, f, z, vec(8, 6, 1, 0, 1, int'(z), 0, 0, 0, 0, 0, 0, 1, 0));
      end
      6'b000010: begin
        step(0, o, f, z, vec(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, o, f, z, vec(9, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0));
      end
      6'b001000: begin
        step(0, o, f, z, vec(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, o, f, z, vec(10, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, o, f, z, vec(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      end
      default: begin
        step(0, o, f, z, vec(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
    endcase
  endtask

  always @(negedge clk) begin
    logic [W-1:0] act, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {state, aluc, alusrca, alusrcb, pcsrc, pcen, iord, memwrite,
             irwrite, regdst, memtoreg, regwrite, done, illegal};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL ctrl_vec t=%0t op=%b funct=%b rst=%b actual=%h expected=%h (state %0d vs %0d)",
                 $time, op, funct, rst, act, e, act[20:17], e[20:17]);
      end
      if (done === 1'b1 && illegal === 1'b1) begin
        errors++;
        $display("FAIL done_illegal_excl t=%0t actual=11 expected=not both", $time);
      end
    end
  end

  logic [5:0] legal_f [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
  logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};

  initial begin
    logic [5:0] o, f;
    // Reset held three cycles with lw on op: everything stays low.
    for (int i = 0; i < 3; i++) step(1, 6'b100011, 6'd0, 1'b1, '0);

    run_instr(6'b100011, 6'd0, 1'b0);
    for (int i = 0; i < 5; i++) run_instr(6'b000000, legal_f[i], 1'b0);
    run_instr(6'b000100, 6'd0, 1'b1);
    run_instr(6'b000100, 6'd0, 1'b0);
    run_instr(6'b101011, 6'd0, 1'b0);
    run_instr(6'b000010, 6'd0, 1'b0);
    run_instr(6'b001000, 6'd0, 1'b0);
    run_instr(6'b111111, 6'd0, 1'b0);
    run_instr(6'b000000, 6'b000111, 1'b0);

    // sw interrupted by reset in MEMWR, then a normal instruction.
    step(0, 6'd5, 6'd9, 1'b0, vec(0, 2, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    step(0, 6'b101011, 6'd0, 1'b0, vec(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 6'b101011, 6'd0, 1'b0, vec(2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(1, 6'b101011, 6'd0, 1'b0, '0);
    run_instr(6'b001000, 6'd0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        o = 6'($urandom_range(0, 63));
      end else begin
        o = ops[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 3) == 0) f = 6'($urandom_range(0, 63));
      else f = legal_f[$urandom_range(0, 4)];
      run_instr(o, f, 1'($urandom_range(0, 1)));
    end

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle MIPS control unit; the driving end of the ALU interface.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and produces every datapath enable and mux select.
- Generates the 3-bit ALU operation code and consumes the ALU zero flag for BEQ.
- Sits between the instruction register (op/funct fields) and the shared datapath: single ALU, register file, unified memory, PC.

Parameters:
- P_STATE_W, 4, width of state register and of o_state debug port.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_op  input  6  instruction opcode, IR[31:26]; valid from DECODE onward.
- i_funct  input  6  R-type function, IR[5:0].
- i_zf  input  1  ALU zero flag (1 when SUB result == 0).
- o_aluc  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- o_alusrca  output  1  0 = PC, 1 = register A.
- o_alusrcb  output  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- o_pcsrc  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- o_pcen  output  1  PC write enable.
- o_iord  output  1  memory address: 0 = PC, 1 = ALUOut.
- o_memwrite  output  1  memory write strobe.
- o_irwrite  output  1  instruction register load.
- o_regdst  output  1  destination: 0 = rt, 1 = rd.
- o_memtoreg  output  1  write-back data: 0 = ALUOut, 1 = MDR.
- o_regwrite  output  1  register file write.
- o_done  output  1  one-cycle pulse in the last state of each instruction.
- o_illegal  output  1  one-cycle pulse on unsupported op/funct.
- o_state  output  P_STATE_W  current state, for debug.

Behaviour:
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, JEX=9, ADDIEX=10, ADDIWB=11.
- Reset:
  - i_rst high at a rising edge puts the state in FETCH, overriding any in-flight instruction (mid-instruction reset abandons it; no writes complete).
  - While i_rst is high, every output is forced to 0, including o_state and o_aluc=000.
  - The first FETCH actions occur in the first cycle after i_rst drops.
- Outputs are Moore-decoded from the state register, except o_pcen, which combines i_zf combinationally in BEQEX. No output depends on i_op/i_funct outside DECODE and RTEX.
- FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluc=010, pcsrc=00, pcen=1. Next state DECODE.
- DECODE: alusrca=0, alusrcb=11, aluc=010 (branch target into ALUOut). Next state by i_op:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> RTEX if funct is legal, else FETCH with o_illegal=1.
  - 000100 (beq) -> BEQEX.
  - 000010 (j) -> JEX.
  - 001000 (addi) -> ADDIEX.
  - Any other op -> FETCH with o_illegal=1 and o_done=0.
- MEMADR: alusrca=1, alusrcb=10, aluc=010. Next MEMRD if op=lw, else MEMWR.
- MEMRD: iord=1 -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, done=1 -> FETCH.
- MEMWR: iord=1, memwrite=1, done=1 -> FETCH.
- RTEX: alusrca=1, alusrcb=00. aluc from funct:
  - 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111.
  - Next RTWB.
- RTWB: regdst=1, memtoreg=0, regwrite=1, done=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluc=110, pcsrc=01, pcen=i_zf, done=1 -> FETCH.
- JEX: pcsrc=10, pcen=1, done=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluc=010 -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, done=1 -> FETCH.
- Outputs not listed for a state are 0.
- Cycles per instruction: lw 5; sw, R-type, addi 4; beq, j 3; illegal 2.
- Unused state encodings 12-15 go to FETCH on the next edge with all outputs 0.
- o_done and o_illegal are never both high.

Test Plan:
- Reset: hold i_rst 3 cycles with op=100011 -> all outputs 0 throughout. First cycle after release: state=0, irwrite=1, pcen=1, aluc=010, alusrcb=01.
- lw: op=100011 -> state sequence 0,1,2,3,4,0. aluc=010 in MEMADR. regwrite=1 and memtoreg=1 only in MEMWB. done pulses once.
- R-type sweep: funct 100000/100010/100100/100101/101010 -> aluc 010/110/000/001/111 in RTEX. RTWB has regdst=1, regwrite=1. 4 cycles each.
- beq:
  - i_zf=1 in BEQEX -> pcen=1, pcsrc=01, aluc=110.
  - Repeat with i_zf=0 -> pcen=0.
  - Both return to FETCH after 3 cycles.
- Illegal: op=111111 -> DECODE goes to FETCH, illegal=1 for exactly 1 cycle, no regwrite/memwrite.
- Same for op=000000 with funct=000111.
- Mid-instruction reset: assert i_rst in MEMWR of sw -> memwrite=0 that cycle. State=0 after the edge, and the next instruction fetches normally.
